// File: rtl/abc_pair_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : abc_pair_counter_if
//  Description : Converter-side handshake and result bus of abc_pair_counter.
//                  x   [7:0] converter sample, valid while eoc=1 after soc fell
//                  eoc       end of conversion (0 = busy, 1 = done)
//                  soc       start-of-conversion request to the converter
//                  out [2:0] count of 2'b00 fields in the last sample (7 = none)
//                The sampler drives soc/out (master); the converter side and
//                result consumer drive x/eoc and read soc/out (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface abc_pair_counter_if;
    logic [7:0] x;
    logic       eoc;
    logic       soc;
    logic [2:0] out;

    modport master (
        input  x,
        input  eoc,
        output soc,
        output out
    );

    modport slave (
        output x,
        output eoc,
        input  soc,
        input  out
    );
endinterface
`default_nettype wire

// File: rtl/abc_pair_counter.sv
`default_nettype none
// ============================================================================
//  Module      : abc_pair_counter
//  Description : Periodic A/D sampler. Runs a soc/eoc handshake with an
//                external converter, counts the 2-bit fields of the returned
//                8-bit sample that equal 2'b00 (0..4), and publishes that
//                count on bus.out exactly once every PERIOD clocks.
//  Ports       : clock  - system clock, rising edge
//                reset_ - synchronous, active-high reset
//                bus    - abc_pair_counter_if.master (x, eoc in; soc, out out)
//  Revision    : 1.0  initial release
// ============================================================================
module abc_pair_counter #(
    parameter int PERIOD = 20
) (
    input  wire                         clock,
    input  wire                         reset_,
    abc_pair_counter_if.master          bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_TIMER_W = 5;
    localparam logic [c_TIMER_W-1:0] c_LAST = c_TIMER_W'(PERIOD - 1);
    localparam logic [2:0]  c_NO_RESULT = 3'b111;

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_REQ  = 2'd1;
    localparam logic [1:0]  c_ACK  = 2'd2;
    localparam logic [1:0]  c_HOLD = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [2:0]             r_res;
    logic [2:0]             r_out;
    logic                   r_soc;

    logic [1:0]             w_state_nxt;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [2:0]             w_count;
    logic                   w_timer_done;
    logic                   w_capture;
    logic                   w_update;

    // ------------------------------------------------------------------------
    // Number of 2'b00 fields in the current converter word
    // ------------------------------------------------------------------------
    always_comb begin
        w_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.x[2*i +: 2] == 2'b00) begin
                w_count = w_count + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    // The timer saturates at PERIOD-1 while a late handshake is pending, so
    // w_timer_done also marks "result is overdue".
    assign w_timer_done = (r_timer == c_LAST);
    assign w_capture    = (r_state == c_ACK) && bus.eoc;

    // Normal publish from HOLD, or an overdue result published directly on
    // the edge that would otherwise have entered HOLD.
    assign w_update = ((r_state == c_HOLD) && w_timer_done) ||
                      (w_capture && w_timer_done);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: w_state_nxt = c_REQ;
            c_REQ:  if (!bus.eoc) w_state_nxt = c_ACK;
            c_ACK:  if (bus.eoc)  w_state_nxt = w_timer_done ? c_REQ : c_HOLD;
            c_HOLD: if (w_timer_done) w_state_nxt = c_REQ;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_update) begin
            w_timer_nxt = '0;
        end else if (!w_timer_done) begin
            w_timer_nxt = r_timer + c_TIMER_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset_) begin
            r_state <= c_IDLE;
            r_timer <= '0;
            r_res   <= 3'd0;
            r_out   <= c_NO_RESULT;
            r_soc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            // soc is a registered decode of the state being entered
            r_soc   <= (w_state_nxt == c_REQ);
            if (w_capture) begin
                r_res <= w_count;
            end
            if (w_update) begin
                r_out <= (r_state == c_HOLD) ? r_res : w_count;
            end
        end
    end

    assign bus.soc = r_soc;
    assign bus.out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_abc_pair_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_abc_pair_counter
//  Description : Directed bench for abc_pair_counter: reset values, handshake
//                timing, 00-field counting, update spacing, late handshake
//                and reset in the middle of a handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_abc_pair_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    abc_pair_counter_if bus ();

    abc_pair_counter #(
        .PERIOD (20)
    ) dut (
        .clock  (clk),
        .reset_ (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered right after the edge that put the DUT in REQ (soc=1, eoc=1).
    // Runs one handshake returning xv, then expects out: prev -> exp exactly
    // len edges after the REQ entry edge.
    task automatic run_period(input string tag, input logic [7:0] xv,
                              input int d1, input int d2, input int len,
                              input logic [2:0] prev, input logic [2:0] exp);
        chk({tag, "_soc_req"}, 8'(bus.soc), 8'd1);
        step(d1);
        bus.eoc = 1'b0;
        step(1);
        chk({tag, "_soc_ack"}, 8'(bus.soc), 8'd0);
        step(d2);
        bus.x   = xv;
        bus.eoc = 1'b1;
        step(1);
        bus.x   = ~xv;  // must be ignored after capture
        chk({tag, "_soc_hold"}, 8'(bus.soc), 8'd0);
        step(len - d1 - d2 - 3);
        chk({tag, "_out_before"}, 8'(bus.out), 8'(prev));
        step(1);
        chk({tag, "_out"}, 8'(bus.out), 8'(exp));
        chk({tag, "_soc_restart"}, 8'(bus.soc), 8'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.x    = 8'h00;
        bus.eoc  = 1'b1;

        // Reset
        step(2);
        chk("rst_soc", 8'(bus.soc), 8'd0);
        chk("rst_out", 8'(bus.out), 8'h07);
        rst = 1'b0;
        step(1);
        chk("first_soc", 8'(bus.soc), 8'd1);

        // First update lands 20 edges after the last reset edge
        run_period("ff", 8'hFF, 2, 4, 19, 3'd7, 3'd0);
        run_period("fc", 8'hFC, 2, 4, 20, 3'd0, 3'd1);
        run_period("f0", 8'hF0, 0, 1, 20, 3'd1, 3'd2);  // single-cycle soc
        run_period("c0", 8'hC0, 3, 6, 20, 3'd2, 3'd3);
        run_period("z0", 8'h00, 1, 0, 20, 3'd3, 3'd4);
        run_period("p33", 8'h33, 2, 4, 20, 3'd4, 3'd2);
        run_period("p55", 8'h55, 2, 4, 20, 3'd2, 3'd0);

        // Late handshake: eoc low for 25 clocks after soc falls
        step(2);
        bus.eoc = 1'b0;
        step(1);
        chk("late_soc_ack", 8'(bus.soc), 8'd0);
        step(25);
        chk("late_out_before", 8'(bus.out), 8'd0);
        bus.x   = 8'hCC;
        bus.eoc = 1'b1;
        step(1);
        bus.x   = 8'h33;
        chk("late_out", 8'(bus.out), 8'd2);
        chk("late_soc", 8'(bus.soc), 8'd1);
        run_period("after_late", 8'hC0, 2, 4, 20, 3'd2, 3'd3);

        // Reset while in ACK
        step(1);
        bus.eoc = 1'b0;
        step(1);
        chk("mid_soc_ack", 8'(bus.soc), 8'd0);
        step(2);
        rst = 1'b1;
        step(1);
        chk("mid_rst_soc", 8'(bus.soc), 8'd0);
        chk("mid_rst_out", 8'(bus.out), 8'h07);
        rst     = 1'b0;
        bus.eoc = 1'b1;
        step(1);
        chk("mid_restart_soc", 8'(bus.soc), 8'd1);
        run_period("post_rst", 8'hFC, 2, 4, 19, 3'd7, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
